// File: rtl/reconfig_pkg.sv
// Shared definitions for the multiboot reconfiguration scheduler and the ICAP core.
// Holds the FSM encodings, design-number width and the flash image validity map.
package reconfig_pkg;

  localparam int DESIGN_W = 5;

  // Bit k set means flash image slot k holds a bootable design.
  localparam logic [16:0] VALID_MASK = 17'h1FF9F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_GUARD = 3'd2,
    ST_FIRE  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  function automatic logic design_valid(input logic [DESIGN_W-1:0] code);
    if (code > 5'd16) return 1'b0;
    return VALID_MASK[code];
  endfunction

endpackage

// File: rtl/reconfig_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational grant, search starts one past the last winner.
// Latency: grant valid in the same cycle as req; pointer advances on upd.
// Backpressure: none; requests are levels, grant only asserted while en is high.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             en,
  input  logic             upd,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               c;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && req[IDX_W'(c)]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(c);
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) begin
      if (gnt_idx == IDX_W'(NREQ - 1)) ptr_d = '0;
      else                             ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reconfig_scheduler.sv
// Multiboot scheduler: grants one requester, validates its image, guards, pulses ICAP reconfigure.
// Latency: ack one edge after req; reconfigure rises GUARD_CYCLES+1 edges after ack.
// Backpressure: requests outside IDLE are ignored; requesters hold req until ack.
module reconfig_scheduler
  import reconfig_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int GUARD_CYCLES   = 1024,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     fastclk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [DESIGN_W*NREQ-1:0] req_design,
  input  logic                     cancel,
  output logic [NREQ-1:0]          ack,
  output logic [DESIGN_W-1:0]      design_num,
  output logic                     reconfigure,
  output logic                     busy,
  output logic                     err_invalid,
  output logic                     err_timeout,
  output logic [2:0]               state_dbg
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_GP = (GUARD_CYCLES > PULSE_CYCLES) ? GUARD_CYCLES : PULSE_CYCLES;
  localparam int MAXC   = (MAX_GP > TIMEOUT_CYCLES) ? MAX_GP : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAXC) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic [DESIGN_W-1:0] design_num_q, design_num_d;
  logic                reconfigure_q, reconfigure_d;
  logic                busy_q, busy_d;
  logic                err_invalid_q, err_invalid_d;
  logic                err_timeout_q, err_timeout_d;

  logic                arb_en, arb_upd;
  logic [NREQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic [DESIGN_W-1:0] design_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_design
    assign design_arr[g] = req_design[g*DESIGN_W +: DESIGN_W];
  end

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .fastclk (fastclk),
    .reset   (reset),
    .req     (req),
    .en      (arb_en),
    .upd     (arb_upd),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    ack_d         = '0;
    design_num_d  = design_num_q;
    err_invalid_d = err_invalid_q;
    err_timeout_d = err_timeout_q;
    arb_en        = 1'b0;
    arb_upd       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        arb_en = 1'b1;
        if (|req) begin
          arb_upd       = 1'b1;
          ack_d         = arb_gnt;
          design_num_d  = design_arr[arb_idx];
          err_invalid_d = 1'b0;
          err_timeout_d = 1'b0;
          state_d       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (design_valid(design_num_q)) begin
          state_d = ST_GUARD;
        end else begin
          err_invalid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (cancel)                                     state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(GUARD_CYCLES - 1))     state_d = ST_FIRE;
        else                                            cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_FIRE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) state_d = ST_WAIT;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_WAIT: begin
        // A successful reboot never returns here; reaching the limit means the ICAP ignored us.
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reconfigure_d = (state_d == ST_FIRE);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      ack_q         <= '0;
      design_num_q  <= '0;
      reconfigure_q <= 1'b0;
      busy_q        <= 1'b0;
      err_invalid_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      design_num_q  <= design_num_d;
      reconfigure_q <= reconfigure_d;
      busy_q        <= busy_d;
      err_invalid_q <= err_invalid_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign ack         = ack_q;
  assign design_num  = design_num_q;
  assign reconfigure = reconfigure_q;
  assign busy        = busy_q;
  assign err_invalid = err_invalid_q;
  assign err_timeout = err_timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_reconfig_scheduler.sv
// Directed bench for reconfig_scheduler with short guard/pulse/timeout parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_reconfig_scheduler;

  logic        fastclk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [14:0] req_design;
  logic        cancel;
  logic [2:0]  ack;
  logic [4:0]  design_num;
  logic        reconfigure;
  logic        busy;
  logic        err_invalid;
  logic        err_timeout;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic saw_pulse;

  always #5 fastclk = ~fastclk;

  reconfig_scheduler #(
    .NREQ(3), .GUARD_CYCLES(8), .PULSE_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .fastclk     (fastclk),
    .reset       (reset),
    .req         (req),
    .req_design  (req_design),
    .cancel      (cancel),
    .ack         (ack),
    .design_num  (design_num),
    .reconfigure (reconfigure),
    .busy        (busy),
    .err_invalid (err_invalid),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  task automatic tick;
    @(posedge fastclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; req_design = '0; cancel = 1'b0;
    tick; tick;
    check("rst_ack", ack, 0);
    check("rst_design", design_num, 0);
    check("rst_reconf", reconfigure, 0);
    check("rst_busy", busy, 0);
    check("rst_err_inv", err_invalid, 0);
    check("rst_err_to", err_timeout, 0);
    check("rst_state", state_dbg, 0);
    reset = 1'b0;

    // Valid request from requester 0, runs through guard, pulse and timeout.
    req_design[4:0] = 5'd2;
    req = 3'b001;
    tick;
    check("v_ack", ack, 3'b001);
    check("v_state_check", state_dbg, 1);
    check("v_design", design_num, 2);
    check("v_busy", busy, 1);
    req = 3'b000;
    for (int j = 1; j <= 29; j++) begin
      tick;
      check($sformatf("v_reconf_%0d", j), reconfigure, (j >= 9 && j <= 12) ? 1 : 0);
      check($sformatf("v_err_to_%0d", j), err_timeout, (j >= 29) ? 1 : 0);
      if (j == 1) begin
        check("v_ack_pulse", ack, 0);
        check("v_state_guard", state_dbg, 2);
      end
      if (j == 13) check("v_state_wait", state_dbg, 4);
      if (j == 29) begin
        check("v_state_idle", state_dbg, 0);
        check("v_busy_idle", busy, 0);
      end
    end

    // Invalid code from requester 1; also clears the sticky timeout on ack.
    req_design[9:5] = 5'd5;
    req = 3'b010;
    tick;
    check("i_ack", ack, 3'b010);
    check("i_err_to_clr", err_timeout, 0);
    check("i_design", design_num, 5);
    check("i_err_inv_early", err_invalid, 0);
    req = 3'b000;
    tick;
    check("i_err_inv", err_invalid, 1);
    check("i_state", state_dbg, 0);
    check("i_busy", busy, 0);
    check("i_reconf", reconfigure, 0);
    check("i_design_hold", design_num, 5);

    // Round-robin order from a fresh pointer, all codes invalid to keep turns short.
    reset = 1'b1; tick; reset = 1'b0;
    req_design = {5'd17, 5'd6, 5'd5};
    req = 3'b111;
    tick; check("rr_g0", ack, 3'b001);
    req = 3'b110; tick;
    tick; check("rr_g1", ack, 3'b010);
    req = 3'b100; tick;
    tick; check("rr_g2", ack, 3'b100);
    req = 3'b011; tick;
    tick; check("rr_g3", ack, 3'b001);
    req = 3'b010; tick;
    tick; check("rr_g4", ack, 3'b010);
    req = 3'b000; tick;

    // Cancel in the third guard cycle; pointer now favours requester 2, then 1.
    req_design[9:5] = 5'd3;
    req = 3'b010;
    tick; check("c_ack", ack, 3'b010);
    req = 3'b000;
    tick; check("c_guard1", state_dbg, 2);
    tick;
    tick; check("c_guard3", state_dbg, 2);
    cancel = 1'b1;
    tick;
    check("c_state", state_dbg, 0);
    check("c_busy", busy, 0);
    check("c_err_inv", err_invalid, 0);
    check("c_err_to", err_timeout, 0);
    cancel = 1'b0;
    saw_pulse = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick;
      if (reconfigure) saw_pulse = 1'b1;
    end
    check("c_no_pulse", saw_pulse, 0);

    // Reset in the second fire cycle truncates the pulse and rewinds the pointer.
    req_design[4:0] = 5'd4;
    req = 3'b001;
    tick; check("r_ack", ack, 3'b001);
    req = 3'b000;
    for (int j = 1; j <= 10; j++) tick;
    check("r_fire", state_dbg, 3);
    check("r_reconf_hi", reconfigure, 1);
    reset = 1'b1;
    tick;
    check("r_reconf_lo", reconfigure, 0);
    check("r_state", state_dbg, 0);
    check("r_busy", busy, 0);
    check("r_design", design_num, 0);
    reset = 1'b0;
    req = 3'b011;
    tick; check("r_first_grant", ack, 3'b001);
    req = 3'b000;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reconfig_scheduler.md
# reconfig_scheduler

Arbitrates FPGA multiboot reconfiguration requests from several requesters (host register write, front-panel switch, watchdog) and sequences the single ICAP multiboot engine. Grants one requester round-robin, validates its 5-bit design number against the flash image map, waits a guard interval so in-flight bus activity can drain, then drives `design_num` and a stretched `reconfigure` pulse into the ICAP core. If the device has not rebooted after a timeout, it flags an error and returns to idle.

## Interface
- `NREQ`, 3: number of requesters.
- `GUARD_CYCLES`, 1024: idle delay between validation and firing, in `fastclk` cycles, ≥1.
- `PULSE_CYCLES`, 4: `reconfigure` high time, ≥2, because the ICAP core samples on `fastclk`/2.
- `TIMEOUT_CYCLES`, 65536: wait after firing before `err_timeout` is raised.
- `fastclk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: level requests. Bit i stays high until `ack[i]`.
- `req_design` in 5×NREQ: design number for requester i, in bits [5i+4:5i].
- `cancel` in 1: aborts during GUARD only.
- `ack` out NREQ: one-cycle grant pulse, one-hot. Reset value 0.
- `design_num` out 5: latched design number to ICAP core. Reset value 5'b00000.
- `reconfigure` out 1: reboot trigger. Reset value 0.
- `busy` out 1: high in any state other than IDLE. Reset value 0.
- `err_invalid` out 1: sticky, cleared on the next `ack`. Reset value 0.
- `err_timeout` out 1: sticky, cleared on the next `ack`. Reset value 0.
- `state_dbg` out 3: current state encoding, for the `test` pins. Reset value IDLE.

## Operation
- States: IDLE(0), CHECK(1), GUARD(2), FIRE(3), WAIT(4).
- IDLE
  - If any `req` bit is high: pick one round-robin, starting from the requester after the last granted one. After reset the search starts at requester 0.
  - Latch `req_design[i]` into `design_num`, pulse `ack[i]`, clear both error flags, go to CHECK.
  - Requests that arrive in any other state are ignored, not queued.
- CHECK: one cycle.
  - Valid codes are 0, 1, 2, 3, 4, 7, 8–15 and 16.
  - Valid code: clear the counter, go to GUARD.
  - Invalid code: set `err_invalid`, go to IDLE. `design_num` keeps the rejected value.
- GUARD: count `GUARD_CYCLES` cycles, then go to FIRE.
  - `cancel` high on any GUARD cycle: go to IDLE with no error and no pulse.
  - `cancel` in any other state has no effect.
- FIRE: `reconfigure`=1 for exactly `PULSE_CYCLES` cycles, then go to WAIT.
- WAIT: count `TIMEOUT_CYCLES` cycles, then set `err_timeout` and go to IDLE.
  - A normal reboot ends WAIT through device reconfiguration, not through this logic.
- `design_num` is held constant from CHECK until the next grant.
- Counter
  - 1 counter, sized ⌈log2(max(GUARD_CYCLES, PULSE_CYCLES, TIMEOUT_CYCLES))⌉+1 bits, counting up from 0.
  - Compared against parameter−1, so there is no wrap.
  - Reset to 0 on every state entry.
- `reset` in any state: next edge forces IDLE, all outputs to reset values, round-robin pointer to 0.
  - A `reconfigure` pulse in progress is truncated.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- `req[i]` high at edge N (in IDLE):
  - `ack[i]`=1 and `state_dbg`=CHECK after edge N.
  - GUARD entered after edge N+1.
- First `reconfigure`=1 cycle follows edge N+1+`GUARD_CYCLES`.
- `reconfigure` falls after edge N+1+`GUARD_CYCLES`+`PULSE_CYCLES`.
- `err_timeout` rises `TIMEOUT_CYCLES` cycles after `reconfigure` falls.
- Back-to-back requests: the earliest next `ack` is the cycle after IDLE is re-entered.

## Structure
- Shared package `reconfig_pkg`:
  - state encodings,
  - `DESIGN_W`=5,
  - design-validity function or constant mask (17-bit, bit k = code k valid).
- The ICAP core uses the same valid-code list.
- Sub-module `rr_arbiter`: parameterised over NREQ. Inputs are request vector, enable and pointer update. Outputs are a one-hot grant and the grant index.
- The FSM, counter and error flags live in the top level.

## Test plan
- Single request, valid code: `req`=3'b001, `req_design[0]`=5'd2, `GUARD_CYCLES`=8, `PULSE_CYCLES`=4.
  - `ack`=001 for 1 cycle, `design_num`=2.
  - `reconfigure` high for cycles 10–13 after the request edge.
- Invalid code: `req_design[1]`=5'd5.
  - `ack`=010, then `err_invalid`=1 one cycle later.
  - `reconfigure` never asserts, `busy` drops after 2 cycles.
- Round-robin fairness with `req`=3'b111 held:
  - grants come in the order 001, 010, 100, 001.
  - Each requester drops its request after its own ack.
- Cancel during GUARD cycle 3: returns to IDLE, no pulse, no error flags.
- Reset mid-operation:
  - `reset` in the 2nd FIRE cycle drops `reconfigure` after the next edge and returns IDLE.
  - A following request from requester 0 is granted first.
- Timeout with `TIMEOUT_CYCLES`=16 and no reboot: `err_timeout`=1 exactly 16 cycles after `reconfigure` falls, cleared on the next `ack`.
